// File: rtl/reg_wb_queue_if.sv
// Bus bundle between the write-back queue and its surroundings: the result-source
// push side, the register-file write port and the two forwarding lookups.
interface reg_wb_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic              drain_en;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_inaddress;
    logic [DATA_W-1:0] rf_in;
    logic [ADDR_W-1:0] q1_address;
    logic              q1_hit;
    logic [DATA_W-1:0] q1_data;
    logic [ADDR_W-1:0] q2_address;
    logic              q2_hit;
    logic [DATA_W-1:0] q2_data;

    modport slave (
        input  push, push_addr, push_data, drain_en, q1_address, q2_address,
        output full, empty, count, overflow, rf_write, rf_inaddress, rf_in,
               q1_hit, q1_data, q2_hit, q2_data
    );

    modport master (
        output push, push_addr, push_data, drain_en, q1_address, q2_address,
        input  full, empty, count, overflow, rf_write, rf_inaddress, rf_in,
               q1_hit, q1_data, q2_hit, q2_data
    );
endinterface

// File: rtl/reg_wb_queue.sv
// FIFO of pending register-file writes with a one-entry output stage feeding the
// register-file write port, plus youngest-match forwarding for two read addresses.
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    reg_wb_queue_if.slave       bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic              r_rf_write;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;

    logic              w_push_ok;
    logic              w_pop_ok;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_q1_hit;
    logic [DATA_W-1:0] w_q1_data;
    logic              w_q2_hit;
    logic [DATA_W-1:0] w_q2_data;

    // Acceptance uses the pre-edge FULL, so a same-cycle pop never frees a slot.
    assign w_push_ok = bus.push && !r_full;
    assign w_pop_ok  = bus.drain_en && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok)
            w_count_nxt = r_count + CNT_W'(1);
        else if (!w_push_ok && w_pop_ok)
            w_count_nxt = r_count - CNT_W'(1);
    end

    // Storage is deliberately not reset; validity comes from the count.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push_ok) begin
            r_mem_addr[r_tail] <= bus.push_addr;
            r_mem_data[r_tail] <= bus.push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_rf_write <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_data  <= '0;
        end else begin
            if (w_push_ok)
                r_tail <= r_tail + PTR_W'(1);
            if (bus.push && r_full)
                r_overflow <= 1'b1;
            if (w_pop_ok) begin
                r_rf_write <= 1'b1;
                r_rf_addr  <= r_mem_addr[r_head];
                r_rf_data  <= r_mem_data[r_head];
                r_head     <= r_head + PTR_W'(1);
            end else begin
                r_rf_write <= 1'b0;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing;
    // the output stage is older than every queued entry, so it goes first.
    always_comb begin
        w_q1_hit  = 1'b0;
        w_q1_data = '0;
        w_q2_hit  = 1'b0;
        w_q2_data = '0;
        if (r_rf_write && r_rf_addr == bus.q1_address) begin
            w_q1_hit  = 1'b1;
            w_q1_data = r_rf_data;
        end
        if (r_rf_write && r_rf_addr == bus.q2_address) begin
            w_q2_hit  = 1'b1;
            w_q2_data = r_rf_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < r_count) begin
                if (r_mem_addr[r_head + PTR_W'(i)] == bus.q1_address) begin
                    w_q1_hit  = 1'b1;
                    w_q1_data = r_mem_data[r_head + PTR_W'(i)];
                end
                if (r_mem_addr[r_head + PTR_W'(i)] == bus.q2_address) begin
                    w_q2_hit  = 1'b1;
                    w_q2_data = r_mem_data[r_head + PTR_W'(i)];
                end
            end
        end
    end

    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.rf_write     = r_rf_write;
    assign bus.rf_inaddress = r_rf_addr;
    assign bus.rf_in        = r_rf_data;
    assign bus.q1_hit       = w_q1_hit;
    assign bus.q1_data      = w_q1_data;
    assign bus.q2_hit       = w_q2_hit;
    assign bus.q2_data      = w_q2_data;
endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed vector table, hand-written corner sequences and
// random traffic against a queue-based reference model.
module tb_reg_wb_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    reg_wb_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Reference model: pending writes as a plain queue plus the output stage.
    typedef struct packed { logic [2:0] a; logic [7:0] d; } ent_t;
    ent_t       mq[$];
    logic       m_ovf = 1'b0;
    logic       m_rfw = 1'b0;
    logic [2:0] m_rfa = '0;
    logic [7:0] m_rfd = '0;

    task automatic model_edge();
        ent_t e;
        bit   was_full;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0; m_rfw = 1'b0; m_rfa = '0; m_rfd = '0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (bus.drain_en && mq.size() > 0) begin
                e = mq.pop_front();
                m_rfw = 1'b1; m_rfa = e.a; m_rfd = e.d;
            end else begin
                m_rfw = 1'b0;
            end
            if (bus.push) begin
                if (was_full) m_ovf = 1'b1;
                else          mq.push_back({bus.push_addr, bus.push_data});
            end
        end
    endtask

    function automatic logic [8:0] model_lookup(input logic [2:0] addr);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == addr) return {1'b1, mq[i].d};
        if (m_rfw && m_rfa == addr) return {1'b1, m_rfd};
        return 9'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic p, input logic [2:0] a, input logic [7:0] d,
                         input logic dr, input logic [2:0] q1, input logic [2:0] q2);
        bus.push = p; bus.push_addr = a; bus.push_data = d;
        bus.drain_en = dr; bus.q1_address = q1; bus.q2_address = q2;
    endtask

    task automatic check_model(input string tag);
        logic [8:0] l1, l2;
        l1 = model_lookup(bus.q1_address);
        l2 = model_lookup(bus.q2_address);
        check({tag, " count"},    32'(bus.count),        32'(mq.size()));
        check({tag, " full"},     32'(bus.full),         32'(mq.size() == DEPTH));
        check({tag, " empty"},    32'(bus.empty),        32'(mq.size() == 0));
        check({tag, " overflow"}, 32'(bus.overflow),     32'(m_ovf));
        check({tag, " rf_write"}, 32'(bus.rf_write),     32'(m_rfw));
        check({tag, " rf_addr"},  32'(bus.rf_inaddress), 32'(m_rfa));
        check({tag, " rf_in"},    32'(bus.rf_in),        32'(m_rfd));
        check({tag, " q1hit"},    32'(bus.q1_hit),       32'(l1[8]));
        check({tag, " q1data"},   32'(bus.q1_data),      32'(l1[7:0]));
        check({tag, " q2hit"},    32'(bus.q2_hit),       32'(l2[8]));
        check({tag, " q2data"},   32'(bus.q2_data),      32'(l2[7:0]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       push; logic [2:0] addr; logic [7:0] data; logic drain; logic [2:0] q1;
        logic [2:0] cnt;  logic full; logic ovf; logic rfw; logic [7:0] rfd; logic hit; logic [7:0] hd;
    } vec_t;
    vec_t tbl[13];

    logic [7:0] wrap_exp[6];

    initial begin
        tbl[0]  = '{1'b1, 3'd3, 8'h2A, 1'b0, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h2A};
        tbl[1]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 8'h2A, 1'b1, 8'h2A};
        tbl[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 3'd0, 8'h10, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b1, 8'h10};
        tbl[4]  = '{1'b1, 3'd1, 8'h11, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b1, 8'h10};
        tbl[5]  = '{1'b1, 3'd2, 8'h12, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b1, 8'h10};
        tbl[6]  = '{1'b1, 3'd3, 8'h13, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b1, 8'h10};
        tbl[7]  = '{1'b1, 3'd4, 8'h14, 1'b0, 3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 8'h2A, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 3'd5, 8'h55, 1'b1, 3'd5, 3'd3, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd2, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 8'h13, 1'b1, 8'h13};
        tbl[12] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 8'h13, 1'b0, 8'h00};

        // Reset while pushing
        drive(1'b1, 3'd6, 8'h77, 1'b0, 3'd6, 3'd6);
        do_reset();
        check("rst empty",    32'(bus.empty),    32'd1);
        check("rst full",     32'(bus.full),     32'd0);
        check("rst count",    32'(bus.count),    32'd0);
        check("rst overflow", 32'(bus.overflow), 32'd0);
        check("rst rf_write", 32'(bus.rf_write), 32'd0);
        check("rst rf_in",    32'(bus.rf_in),    32'd0);
        check("rst q1hit",    32'(bus.q1_hit),   32'd0);
        check("rst q2hit",    32'(bus.q2_hit),   32'd0);

        // Directed table: single write, fill/overflow, full push+pop, ordered drain
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].push, tbl[i].addr, tbl[i].data, tbl[i].drain, tbl[i].q1, 3'd7);
            tick();
            check($sformatf("vec%0d count", i),    32'(bus.count),    32'(tbl[i].cnt));
            check($sformatf("vec%0d full", i),     32'(bus.full),     32'(tbl[i].full));
            check($sformatf("vec%0d empty", i),    32'(bus.empty),    32'(tbl[i].cnt == 0));
            check($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'(tbl[i].ovf));
            check($sformatf("vec%0d rf_write", i), 32'(bus.rf_write), 32'(tbl[i].rfw));
            check($sformatf("vec%0d rf_in", i),    32'(bus.rf_in),    32'(tbl[i].rfd));
            check($sformatf("vec%0d q1hit", i),    32'(bus.q1_hit),   32'(tbl[i].hit));
            check($sformatf("vec%0d q1data", i),   32'(bus.q1_data),  32'(tbl[i].hd));
        end

        // Youngest match on address 5
        do_reset();
        drive(1'b1, 3'd5, 8'h11, 1'b0, 3'd0, 3'd5); tick();
        drive(1'b1, 3'd5, 8'h22, 1'b0, 3'd0, 3'd5); tick();
        check("ym count", 32'(bus.count), 32'd2);
        check("ym q2data pre", 32'(bus.q2_data), 32'h22);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd5); tick();
        check("ym rf first", 32'(bus.rf_in), 32'h11);
        check("ym q2data mid", 32'(bus.q2_data), 32'h22);
        tick();
        check("ym rf second", 32'(bus.rf_in), 32'h22);
        check("ym rf_write second", 32'(bus.rf_write), 32'd1);
        check("ym q2data out", 32'(bus.q2_data), 32'h22);
        tick();
        check("ym q2hit done", 32'(bus.q2_hit), 32'd0);

        // Steady push+pop across pointer wrap
        do_reset();
        drive(1'b1, 3'd1, 8'hA0, 1'b0, 3'd0, 3'd0); tick();
        drive(1'b1, 3'd2, 8'hA1, 1'b0, 3'd0, 3'd0); tick();
        wrap_exp = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'(i), 8'hB0 + 8'(i), 1'b1, 3'd0, 3'd0);
            tick();
            check($sformatf("wrap%0d count", i), 32'(bus.count), 32'd2);
            check($sformatf("wrap%0d full", i),  32'(bus.full),  32'd0);
            check($sformatf("wrap%0d empty", i), 32'(bus.empty), 32'd0);
            check($sformatf("wrap%0d rf_in", i), 32'(bus.rf_in), 32'(wrap_exp[i]));
        end

        // Reset with 3 queued and an output-stage write in flight
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i), 8'hC0 + 8'(i), 1'b0, 3'd0, 3'd0);
            tick();
        end
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0); tick();
        check("mid count", 32'(bus.count), 32'd3);
        check("mid rf_write", 32'(bus.rf_write), 32'd1);
        drive(1'b1, 3'd0, 8'hEE, 1'b1, 3'd0, 3'd0);
        do_reset();
        check("mid rst count", 32'(bus.count), 32'd0);
        check("mid rst rf_write", 32'(bus.rf_write), 32'd0);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid post%0d rf_write", i), 32'(bus.rf_write), 32'd0);
        end

        // Random traffic against the model, with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 9) < 5), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 99) < 2);
            tick();
            rst = 1'b0;
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
